// File: rtl/spmv_mem_arb_pkg.sv
// Shared definitions for the SpMV memory-port arbiter: arbitration modes and
// the channel-id field width that sits in the low bits of every load tag.
package spmv_mem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Width of the channel-id field at the bottom of a load tag.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spmv_mem_arb_rr_arbiter.sv
// Channel arbiter: fixed priority (highest index wins) or round-robin that
// starts its search at a rotating pointer and skips ineligible channels.
module spmv_rr_arbiter
  import spmv_mem_arb_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CH_W   = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] elig,
  input  arb_mode_e         mode,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx,
  output logic              grant_vld
);

  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] elig_rot;
  logic [CH_W:0]     rr_off;
  logic [CH_W:0]     rr_sum;

  always_comb begin
    grant_vld = |elig;
    grant_idx = '0;
    rr_off    = '0;
    rr_sum    = '0;
    elig_rot  = NUM_CH'({elig, elig} >> ptr_q);
    if (mode == ARB_RR) begin
      // Descending scan so the lowest offset from the pointer wins.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (elig_rot[i]) rr_off = (CH_W+1)'(i);
      end
      rr_sum = {1'b0, ptr_q} + rr_off;
      if (rr_sum >= (CH_W+1)'(NUM_CH)) rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      grant_idx = rr_sum[CH_W-1:0];
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (elig[i]) grant_idx = CH_W'(i);
      end
    end
    grant = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;

    ptr_d = ptr_q;
    if (advance && grant_vld) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/spmv_mem_arb.sv
// N-channel memory-port arbiter for the SpMV PE: per-channel request FIFOs,
// one registered issue port, outstanding-load limit and tag-routed responses.
module spmv_mem_arb
  import spmv_mem_arb_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int ADDR_W     = 48,
  parameter int DATA_W     = 64,
  parameter int UTAG_W     = 2,
  parameter int FIFO_DEPTH = 32,
  parameter int AF_MARGIN  = 4,
  parameter int ARB_MODE   = 0,
  parameter int MAX_OUTST  = 64,
  localparam int CH_W      = ch_width(NUM_CH),
  localparam int TAG_W     = UTAG_W + CH_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_req_push,
  input  logic [NUM_CH-1:0]        ch_req_st,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_d,
  input  logic [NUM_CH*UTAG_W-1:0] ch_req_utag,
  output logic [NUM_CH-1:0]        ch_req_afull,
  output logic [NUM_CH-1:0]        ch_overflow,
  output logic                     req_mem_ld,
  output logic                     req_mem_st,
  output logic [ADDR_W-1:0]        req_mem_addr,
  output logic [DATA_W-1:0]        req_mem_d_or_tag,
  input  logic                     req_mem_stall,
  input  logic                     rsp_mem_push,
  input  logic [TAG_W-1:0]         rsp_mem_tag,
  input  logic [DATA_W-1:0]        rsp_mem_q,
  output logic                     rsp_mem_stall,
  output logic [NUM_CH-1:0]        ch_rsp_push,
  output logic [UTAG_W-1:0]        ch_rsp_utag,
  output logic [DATA_W-1:0]        ch_rsp_q,
  input  logic [NUM_CH-1:0]        ch_rsp_stall,
  output logic                     busy
);

  // Handshake: a push is accepted unless the FIFO is full (then it is dropped
  // and flagged); req_mem_stall only blocks new pops, a registered issue is
  // never withdrawn; responses are single-cycle pulses with no acceptance.
  localparam int ENT_W = 1 + ADDR_W + DATA_W + UTAG_W;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int OW    = $clog2(MAX_OUTST + 1);

  logic [NUM_CH-1:0] empty, elig, pop, grant;
  logic [ENT_W-1:0]  head [NUM_CH];
  logic [CH_W-1:0]   grant_idx;
  logic              grant_vld, do_pop, ld_ok;
  logic [OW:0]       ld_pend;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d, full, wr_en;
    logic [ENT_W-1:0] wr_ent;

    assign full            = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty[g]        = (cnt_q == '0);
    assign wr_en           = ch_req_push[g] & ~full;
    assign wr_ent          = {ch_req_st[g], ch_req_addr[g*ADDR_W +: ADDR_W],
                              ch_req_d[g*DATA_W +: DATA_W], ch_req_utag[g*UTAG_W +: UTAG_W]};
    assign head[g]         = mem_q[rd_ptr_q];
    assign elig[g]         = ~empty[g] & (head[g][ENT_W-1] | ld_ok);
    assign ch_req_afull[g] = (cnt_q >= CNT_W'(FIFO_DEPTH - AF_MARGIN));
    assign ch_overflow[g]  = ovf_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(wr_en);
      rd_ptr_d = rd_ptr_q + AW'(pop[g]);
      cnt_d    = cnt_q + CNT_W'(wr_en) - CNT_W'(pop[g]);
      ovf_d    = ovf_q | (ch_req_push[g] & full);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        cnt_q    <= cnt_d;
        ovf_q    <= ovf_d;
      end
    end

    always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_ent;
    end
  end

  spmv_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .elig      (elig),
    .mode      ((ARB_MODE == 1) ? ARB_RR : ARB_FIXED),
    .advance   (~req_mem_stall),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  logic              iss_ld_q, iss_ld_d, iss_st_q, iss_st_d;
  logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
  logic [DATA_W-1:0] iss_dt_q, iss_dt_d, ld_tag;
  logic [ENT_W-1:0]  sel_ent;
  logic              sel_st;
  logic [OW-1:0]     outst_q, outst_d;
  logic              outst_dec;

  // A popped load sits in the issue register for a cycle before it is
  // counted, so it has to be included in the limit check.
  assign ld_pend = {1'b0, outst_q} + (OW+1)'(iss_ld_q);
  assign ld_ok   = (ld_pend < (OW+1)'(MAX_OUTST));
  assign do_pop  = grant_vld & ~req_mem_stall;
  assign pop     = grant & {NUM_CH{do_pop}};

  always_comb begin
    sel_ent = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant[i]) sel_ent = sel_ent | head[i];
    end
    sel_st = sel_ent[ENT_W-1];

    ld_tag                  = '0;
    ld_tag[CH_W-1:0]        = grant_idx;
    ld_tag[CH_W +: UTAG_W]  = sel_ent[UTAG_W-1:0];

    iss_ld_d   = do_pop & ~sel_st;
    iss_st_d   = do_pop & sel_st;
    iss_addr_d = do_pop ? sel_ent[UTAG_W+DATA_W +: ADDR_W] : iss_addr_q;
    iss_dt_d   = iss_dt_q;
    if (do_pop) iss_dt_d = sel_st ? sel_ent[UTAG_W +: DATA_W] : ld_tag;

    outst_dec = rsp_mem_push & (outst_q != '0);
    outst_d   = outst_q + OW'(iss_ld_q) - OW'(outst_dec);
  end

  logic [NUM_CH-1:0] rsp_push_q, rsp_push_d;
  logic [UTAG_W-1:0] rsp_utag_q, rsp_utag_d;
  logic [DATA_W-1:0] rsp_q_q, rsp_q_d;
  logic              rsp_stall_q, rsp_stall_d;
  logic [CH_W-1:0]   rsp_ch;
  logic              rsp_ok;

  // With no loads in flight a response is stale (e.g. it crossed a reset).
  always_comb begin
    rsp_ch      = rsp_mem_tag[CH_W-1:0];
    rsp_ok      = rsp_mem_push & (outst_q != '0) & ({1'b0, rsp_ch} < (CH_W+1)'(NUM_CH));
    rsp_push_d  = rsp_ok ? (NUM_CH'(1) << rsp_ch) : '0;
    rsp_utag_d  = rsp_mem_push ? rsp_mem_tag[CH_W +: UTAG_W] : rsp_utag_q;
    rsp_q_d     = rsp_mem_push ? rsp_mem_q : rsp_q_q;
    rsp_stall_d = |ch_rsp_stall;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_ld_q    <= 1'b0;
      iss_st_q    <= 1'b0;
      iss_addr_q  <= '0;
      iss_dt_q    <= '0;
      outst_q     <= '0;
      rsp_push_q  <= '0;
      rsp_utag_q  <= '0;
      rsp_q_q     <= '0;
      rsp_stall_q <= 1'b0;
    end else begin
      iss_ld_q    <= iss_ld_d;
      iss_st_q    <= iss_st_d;
      iss_addr_q  <= iss_addr_d;
      iss_dt_q    <= iss_dt_d;
      outst_q     <= outst_d;
      rsp_push_q  <= rsp_push_d;
      rsp_utag_q  <= rsp_utag_d;
      rsp_q_q     <= rsp_q_d;
      rsp_stall_q <= rsp_stall_d;
    end
  end

  // Issue strobes are squashed during the reset cycle itself.
  assign req_mem_ld       = iss_ld_q & ~rst;
  assign req_mem_st       = iss_st_q & ~rst;
  assign req_mem_addr     = iss_addr_q;
  assign req_mem_d_or_tag = iss_dt_q;
  assign rsp_mem_stall    = rsp_stall_q;
  assign ch_rsp_push      = rsp_push_q;
  assign ch_rsp_utag      = rsp_utag_q;
  assign ch_rsp_q         = rsp_q_q;
  assign busy             = ~(&empty) | iss_ld_q | iss_st_q | (outst_q != '0);

endmodule

// File: tb/tb_spmv_mem_arb.sv
// Directed bench for spmv_mem_arb: three instances (fixed, round-robin, and
// fixed with a two-load limit) share one stimulus bus.
module tb_spmv_mem_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   ch_req_push, ch_req_st;
  logic [143:0] ch_req_addr;
  logic [191:0] ch_req_d;
  logic [5:0]   ch_req_utag;
  logic         req_mem_stall, rsp_mem_push;
  logic [3:0]   rsp_mem_tag;
  logic [63:0]  rsp_mem_q;
  logic [2:0]   ch_rsp_stall;

  logic [2:0]   afull [3];
  logic [2:0]   ovf [3];
  logic         iss_ld [3];
  logic         iss_st [3];
  logic [47:0]  iss_addr [3];
  logic [63:0]  iss_dt [3];
  logic         rstall [3];
  logic [2:0]   rpush [3];
  logic [1:0]   rutag [3];
  logic [63:0]  rq [3];
  logic         busy [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [33:0] exp_q[$];

  always #5 clk = ~clk;

  spmv_mem_arb #(.ARB_MODE(0), .MAX_OUTST(64)) dut_fx (
    .clk(clk), .rst(rst), .ch_req_push(ch_req_push), .ch_req_st(ch_req_st),
    .ch_req_addr(ch_req_addr), .ch_req_d(ch_req_d), .ch_req_utag(ch_req_utag),
    .ch_req_afull(afull[0]), .ch_overflow(ovf[0]), .req_mem_ld(iss_ld[0]),
    .req_mem_st(iss_st[0]), .req_mem_addr(iss_addr[0]), .req_mem_d_or_tag(iss_dt[0]),
    .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
    .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rstall[0]), .ch_rsp_push(rpush[0]),
    .ch_rsp_utag(rutag[0]), .ch_rsp_q(rq[0]), .ch_rsp_stall(ch_rsp_stall), .busy(busy[0])
  );

  spmv_mem_arb #(.ARB_MODE(1), .MAX_OUTST(64)) dut_rr (
    .clk(clk), .rst(rst), .ch_req_push(ch_req_push), .ch_req_st(ch_req_st),
    .ch_req_addr(ch_req_addr), .ch_req_d(ch_req_d), .ch_req_utag(ch_req_utag),
    .ch_req_afull(afull[1]), .ch_overflow(ovf[1]), .req_mem_ld(iss_ld[1]),
    .req_mem_st(iss_st[1]), .req_mem_addr(iss_addr[1]), .req_mem_d_or_tag(iss_dt[1]),
    .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
    .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rstall[1]), .ch_rsp_push(rpush[1]),
    .ch_rsp_utag(rutag[1]), .ch_rsp_q(rq[1]), .ch_rsp_stall(ch_rsp_stall), .busy(busy[1])
  );

  spmv_mem_arb #(.ARB_MODE(0), .MAX_OUTST(2)) dut_lim (
    .clk(clk), .rst(rst), .ch_req_push(ch_req_push), .ch_req_st(ch_req_st),
    .ch_req_addr(ch_req_addr), .ch_req_d(ch_req_d), .ch_req_utag(ch_req_utag),
    .ch_req_afull(afull[2]), .ch_overflow(ovf[2]), .req_mem_ld(iss_ld[2]),
    .req_mem_st(iss_st[2]), .req_mem_addr(iss_addr[2]), .req_mem_d_or_tag(iss_dt[2]),
    .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
    .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rstall[2]), .ch_rsp_push(rpush[2]),
    .ch_rsp_utag(rutag[2]), .ch_rsp_q(rq[2]), .ch_rsp_stall(ch_rsp_stall), .busy(busy[2])
  );

  typedef struct {
    logic [3:0]  tag;
    logic [63:0] q;
    logic [2:0]  stall;
    logic [2:0]  exp_push;
    logic [1:0]  exp_utag;
    logic        exp_rstall;
  } rsp_vec_t;

  rsp_vec_t rv [4];

  // ---------------- clock / reset helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_push();
    ch_req_push = '0;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    ch_req_push   = '0;
    ch_req_st     = '0;
    ch_req_addr   = '0;
    ch_req_d      = '0;
    ch_req_utag   = '0;
    req_mem_stall = 1'b0;
    rsp_mem_push  = 1'b0;
    rsp_mem_tag   = '0;
    rsp_mem_q     = '0;
    ch_rsp_stall  = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int ch, input logic st, input logic [47:0] addr,
                         input logic [63:0] d, input logic [1:0] utag);
    ch_req_push[ch]          = 1'b1;
    ch_req_st[ch]            = st;
    ch_req_addr[ch*48 +: 48] = addr;
    ch_req_d[ch*64 +: 64]    = d;
    ch_req_utag[ch*2 +: 2]   = utag;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] mk(input logic ld, input logic st,
                                     input logic [15:0] a, input logic [15:0] d);
    return {ld, st, a, d};
  endfunction

  function automatic logic [33:0] obs(input int s);
    return {iss_ld[s], iss_st[s], iss_addr[s][15:0], iss_dt[s][15:0]};
  endfunction

  task automatic run_issue_check(input int s, input int budget, input string name,
                                 output int idle);
    int started;
    started = 0;
    idle    = 0;
    for (int c = 0; c < budget && exp_q.size() > 0; c++) begin
      if (iss_ld[s] || iss_st[s]) begin
        check(name, 64'(obs(s)), 64'(exp_q.pop_front()));
        started = 1;
      end else if (started != 0) begin
        idle++;
      end
      tick();
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d issues missing, expected 0 missing", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int idle;

    rv[0] = '{tag: 4'b1001, q: 64'hDEAD, stall: 3'b000, exp_push: 3'b010, exp_utag: 2'd2, exp_rstall: 1'b0};
    rv[1] = '{tag: 4'b0000, q: 64'hBEEF, stall: 3'b001, exp_push: 3'b001, exp_utag: 2'd0, exp_rstall: 1'b1};
    rv[2] = '{tag: 4'b1110, q: 64'h1234, stall: 3'b000, exp_push: 3'b100, exp_utag: 2'd3, exp_rstall: 1'b0};
    rv[3] = '{tag: 4'b0111, q: 64'h5555, stall: 3'b100, exp_push: 3'b000, exp_utag: 2'd1, exp_rstall: 1'b1};

    // ---- reset state ----
    do_reset();
    check("rst_ld", 64'(iss_ld[0]), 0);
    check("rst_st", 64'(iss_st[0]), 0);
    check("rst_busy", 64'(busy[0]), 0);
    check("rst_afull", 64'(afull[0]), 0);
    check("rst_ovf", 64'(ovf[0]), 0);
    check("rst_rsp_push", 64'(rpush[0]), 0);
    check("rst_rsp_stall", 64'(rstall[0]), 0);

    // ---- fixed priority: three loads pushed together ----
    for (int c = 0; c < 3; c++) set_req(c, 1'b0, 48'h100 + 48'(c), 64'h0, 2'(c));
    tick();
    clear_push();
    check("fx_not_early", 64'(iss_ld[0]), 0);
    tick();
    check("fx_latency", 64'(iss_ld[0]), 1);
    exp_q.push_back(mk(1'b1, 1'b0, 16'h102, 16'hA));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h101, 16'h5));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h100, 16'h0));
    run_issue_check(0, 10, "fx_order", idle);
    check("fx_back_to_back", 64'(idle), 0);

    // ---- load tag packing ----
    set_req(1, 1'b0, 48'h1000, 64'h0, 2'd2);
    tick();
    clear_push();
    tick();
    check("tag_ld", 64'(iss_ld[0]), 1);
    check("tag_addr", 64'(iss_addr[0]), 64'h1000);
    check("tag_value", iss_dt[0], 64'b1001);
    tick();

    // ---- response routing table (4 loads outstanding on dut_fx) ----
    for (int v = 0; v < 4; v++) begin
      rsp_mem_push = 1'b1;
      rsp_mem_tag  = rv[v].tag;
      rsp_mem_q    = rv[v].q;
      ch_rsp_stall = rv[v].stall;
      tick();
      rsp_mem_push = 1'b0;
      check($sformatf("rsp_push_%0d", v), 64'(rpush[0]), 64'(rv[v].exp_push));
      check($sformatf("rsp_stall_%0d", v), 64'(rstall[0]), 64'(rv[v].exp_rstall));
      if (rv[v].exp_push != 3'b000) begin
        check($sformatf("rsp_utag_%0d", v), 64'(rutag[0]), 64'(rv[v].exp_utag));
        check($sformatf("rsp_q_%0d", v), rq[0], rv[v].q);
      end
    end
    ch_rsp_stall = '0;
    tick();
    check("rsp_one_cycle", 64'(rpush[0]), 0);

    // ---- stall in the issue cycle does not retract the issue ----
    set_req(0, 1'b1, 48'h200, 64'h11, 2'd0);
    tick();
    set_req(0, 1'b1, 48'h201, 64'h22, 2'd0);
    tick();
    clear_push();
    req_mem_stall = 1'b1;
    #1;
    check("stall_keep_st", 64'(iss_st[0]), 1);
    check("stall_keep_addr", 64'(iss_addr[0]), 64'h200);
    tick();
    check("stall_block", 64'(iss_st[0]), 0);
    req_mem_stall = 1'b0;
    tick();
    check("stall_resume_st", 64'(iss_st[0]), 1);
    check("stall_resume_d", iss_dt[0], 64'h22);

    // ---- round robin with a 5-cycle stall ----
    do_reset();
    req_mem_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 3; c++)
        set_req(c, 1'b1, 48'(c * 16 + k), 64'(16'h100 + 16'(c * 16 + k)), 2'd0);
      tick();
      check($sformatf("rr_stall_%0d", k), 64'(iss_ld[1] | iss_st[1]), 0);
    end
    clear_push();
    tick();
    check("rr_stall_4", 64'(iss_ld[1] | iss_st[1]), 0);
    req_mem_stall = 1'b0;
    tick();
    for (int k = 0; k < 4; k++)
      for (int c = 0; c < 3; c++)
        exp_q.push_back(mk(1'b0, 1'b1, 16'(c * 16 + k), 16'h100 + 16'(c * 16 + k)));
    run_issue_check(1, 30, "rr_order", idle);
    check("rr_no_idle", 64'(idle), 0);

    // ---- outstanding-load limit of 2 ----
    do_reset();
    req_mem_stall = 1'b1;
    set_req(2, 1'b0, 48'h20, 64'h0, 2'd0);
    set_req(0, 1'b1, 48'h30, 64'h77, 2'd0);
    tick();
    clear_push();
    set_req(2, 1'b0, 48'h21, 64'h0, 2'd0);
    tick();
    clear_push();
    set_req(2, 1'b0, 48'h22, 64'h0, 2'd0);
    tick();
    clear_push();
    req_mem_stall = 1'b0;
    tick();
    exp_q.push_back(mk(1'b1, 1'b0, 16'h20, 16'h2));
    exp_q.push_back(mk(1'b1, 1'b0, 16'h21, 16'h2));
    exp_q.push_back(mk(1'b0, 1'b1, 16'h30, 16'h77));
    run_issue_check(2, 10, "lim_order", idle);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("lim_held_%0d", c), 64'(iss_ld[2] | iss_st[2]), 0);
      tick();
    end
    check("lim_busy", 64'(busy[2]), 1);
    rsp_mem_push = 1'b1;
    rsp_mem_tag  = 4'b0010;
    rsp_mem_q    = 64'hCAFE;
    tick();
    rsp_mem_push = 1'b0;
    check("lim_rsp_push", 64'(rpush[2]), 64'b100);
    exp_q.push_back(mk(1'b1, 1'b0, 16'h22, 16'h2));
    run_issue_check(2, 8, "lim_release", idle);

    // ---- almost-full and overflow on a depth-32 FIFO ----
    do_reset();
    req_mem_stall = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      set_req(0, 1'b1, 48'(n), 64'(n), 2'd0);
      tick();
      check($sformatf("afull_%0d", n), 64'(afull[0][0]), 64'(n >= 28));
      check($sformatf("ovf_%0d", n), 64'(ovf[0][0]), 64'(n >= 33));
    end
    clear_push();
    req_mem_stall = 1'b0;
    tick();
    tick();
    check("ovf_sticky", 64'(ovf[0][0]), 1);

    // ---- reset mid-operation ----
    do_reset();
    set_req(1, 1'b0, 48'h40, 64'h0, 2'd1);
    tick();
    clear_push();
    tick();
    tick();
    set_req(0, 1'b0, 48'h50, 64'h0, 2'd0);
    set_req(2, 1'b0, 48'h60, 64'h0, 2'd0);
    tick();
    clear_push();
    tick();
    check("pre_rst_issue", 64'(iss_ld[0]), 1);
    check("pre_rst_busy", 64'(busy[0]), 1);
    rst = 1'b1;
    #1;
    check("rst_squash_ld", 64'(iss_ld[0]), 0);
    tick();
    rst = 1'b0;
    check("post_rst_ld", 64'(iss_ld[0]), 0);
    check("post_rst_busy", 64'(busy[0]), 0);
    check("post_rst_ovf", 64'(ovf[0]), 0);
    check("post_rst_rsp", 64'(rpush[0]), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post_rst_idle_%0d", c), 64'(iss_ld[0] | iss_st[0]), 0);
    end
    rsp_mem_push = 1'b1;
    rsp_mem_tag  = 4'b0001;
    rsp_mem_q    = 64'hBAD;
    tick();
    rsp_mem_push = 1'b0;
    check("late_rsp_drop", 64'(rpush[0]), 0);
    check("late_rsp_busy", 64'(busy[0]), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
